// File: rtl/fifo_ram.sv
// Simple dual-port storage array for sync_fifo: one write port and one
// read port with a registered output. The output register clears on reset.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // The array has no reset so that it can map onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // The reset input is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with a registered read port. The pointers carry an
// extra wrap bit so that full and empty can be told apart without a counter.
module sync_fifo #(
    parameter int WIDTH    = 8,
    parameter int PTRWIDTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid,
    input  logic [WIDTH-1:0]    din,
    input  logic                load,
    output logic [WIDTH-1:0]    dout,
    output logic                fifo_valid,
    output logic                full,
    output logic                empty,
    output logic [PTRWIDTH:0]   usedw
);

    localparam logic [PTRWIDTH:0] PTR_ONE = 1;

    logic [PTRWIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [PTRWIDTH:0] rd_ptr_q, rd_ptr_d;
    logic              fifo_valid_q;
    logic              wr_en;
    logic              rd_en;

    // Both acceptances are judged on the flags as they stand before the edge.
    assign wr_en = valid & ~full;
    assign rd_en = load & ~empty;

    assign usedw = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTRWIDTH] != rd_ptr_q[PTRWIDTH]) &&
                   (wr_ptr_q[PTRWIDTH-1:0] == rd_ptr_q[PTRWIDTH-1:0]);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_valid_q <= rd_en;
        end
    end

    // A reset edge must not write the array either, so the stored words are
    // effectively discarded by the pointer reset alone.
    fifo_ram #(
        .WIDTH (WIDTH),
        .AW    (PTRWIDTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en & ~rst_n),
        .waddr (wr_ptr_q[PTRWIDTH-1:0]),
        .wdata (din),
        .re    (rd_en),
        .raddr (rd_ptr_q[PTRWIDTH-1:0]),
        .rdata (dout)
    );

    assign fifo_valid = fifo_valid_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a table of per-cycle vectors with expected
// outputs, followed by hand-written reset and held-strobe sequences.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic [7:0] din;
    logic       load;
    logic [7:0] dout;
    logic       fifo_valid;
    logic       full;
    logic       empty;
    logic [2:0] usedw;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic [7:0] e_dout;
        logic       e_fv;
        logic [2:0] e_usedw;
        logic       e_full;
        logic       e_empty;
    } vec_t;

    vec_t vecs[$];

    sync_fifo #(.WIDTH(8), .PTRWIDTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid      (valid),
        .din        (din),
        .load       (load),
        .dout       (dout),
        .fifo_valid (fifo_valid),
        .full       (full),
        .empty      (empty),
        .usedw      (usedw)
    );

    always #5 clk = ~clk;

    task automatic add(input logic v, input logic [7:0] d, input logic l,
                       input logic [7:0] ed, input logic efv, input logic [2:0] eu,
                       input logic ef, input logic ee);
        vec_t t;
        t.v = v; t.d = d; t.l = l;
        t.e_dout = ed; t.e_fv = efv; t.e_usedw = eu; t.e_full = ef; t.e_empty = ee;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [7:0] ed, input logic efv,
                         input logic [2:0] eu, input logic ef, input logic ee);
        checks++;
        if ({dout, fifo_valid, usedw, full, empty} !== {ed, efv, eu, ef, ee}) begin
            errors++;
            $display("FAIL %s: got dout=%02h fv=%0b usedw=%0d full=%0b empty=%0b, want dout=%02h fv=%0b usedw=%0d full=%0b empty=%0b",
                     name, dout, fifo_valid, usedw, full, empty, ed, efv, eu, ef, ee);
        end else begin
            $display("ok   %s: dout=%02h fv=%0b usedw=%0d full=%0b empty=%0b",
                     name, dout, fifo_valid, usedw, full, empty);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d, input logic l);
        rst_n = r; valid = v; din = d; load = l;
        @(posedge clk);
        #1;
        rst_n = 1'b0; valid = 1'b0; load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; valid = 1'b0; din = 8'h00; load = 1'b0;

        // Fill, overflow, drain, underflow
        add(1, 8'hAA, 0, 8'h00, 0, 3'd1, 0, 0);
        add(1, 8'h11, 0, 8'h00, 0, 3'd2, 0, 0);
        add(1, 8'h22, 0, 8'h00, 0, 3'd3, 0, 0);
        add(1, 8'h33, 0, 8'h00, 0, 3'd4, 1, 0);
        add(1, 8'h44, 0, 8'h00, 0, 3'd4, 1, 0);
        add(0, 8'h00, 1, 8'hAA, 1, 3'd3, 0, 0);
        add(0, 8'h00, 0, 8'hAA, 0, 3'd3, 0, 0);
        add(0, 8'h00, 1, 8'h11, 1, 3'd2, 0, 0);
        add(0, 8'h00, 1, 8'h22, 1, 3'd1, 0, 0);
        add(0, 8'h00, 1, 8'h33, 1, 3'd0, 0, 1);
        add(0, 8'h00, 1, 8'h33, 0, 3'd0, 0, 1);
        // Wrap: push 3, pop 3, push 4, pop 4
        add(1, 8'hAA, 0, 8'h33, 0, 3'd1, 0, 0);
        add(1, 8'h11, 0, 8'h33, 0, 3'd2, 0, 0);
        add(1, 8'h22, 0, 8'h33, 0, 3'd3, 0, 0);
        add(0, 8'h00, 1, 8'hAA, 1, 3'd2, 0, 0);
        add(0, 8'h00, 1, 8'h11, 1, 3'd1, 0, 0);
        add(0, 8'h00, 1, 8'h22, 1, 3'd0, 0, 1);
        add(1, 8'hAA, 0, 8'h22, 0, 3'd1, 0, 0);
        add(1, 8'h11, 0, 8'h22, 0, 3'd2, 0, 0);
        add(1, 8'h22, 0, 8'h22, 0, 3'd3, 0, 0);
        add(1, 8'h33, 0, 8'h22, 0, 3'd4, 1, 0);
        add(0, 8'h00, 1, 8'hAA, 1, 3'd3, 0, 0);
        add(0, 8'h00, 1, 8'h11, 1, 3'd2, 0, 0);
        add(0, 8'h00, 1, 8'h22, 1, 3'd1, 0, 0);
        add(0, 8'h00, 1, 8'h33, 1, 3'd0, 0, 1);
        // Simultaneous push/pop at usedw=2
        add(1, 8'h66, 0, 8'h33, 0, 3'd1, 0, 0);
        add(1, 8'h77, 0, 8'h33, 0, 3'd2, 0, 0);
        add(1, 8'h55, 1, 8'h66, 1, 3'd2, 0, 0);
        add(0, 8'h00, 1, 8'h77, 1, 3'd1, 0, 0);
        add(0, 8'h00, 1, 8'h55, 1, 3'd0, 0, 1);
        // Simultaneous while empty: write only
        add(1, 8'h88, 1, 8'h55, 0, 3'd1, 0, 0);
        add(1, 8'h99, 0, 8'h55, 0, 3'd2, 0, 0);
        add(1, 8'h10, 0, 8'h55, 0, 3'd3, 0, 0);
        add(1, 8'h20, 0, 8'h55, 0, 3'd4, 1, 0);
        // Simultaneous while full: read only, 0xEE lost
        add(1, 8'hEE, 1, 8'h88, 1, 3'd3, 0, 0);
        add(0, 8'h00, 1, 8'h99, 1, 3'd2, 0, 0);
        add(0, 8'h00, 1, 8'h10, 1, 3'd1, 0, 0);
        add(0, 8'h00, 1, 8'h20, 1, 3'd0, 0, 1);
        add(0, 8'h00, 1, 8'h20, 0, 3'd0, 0, 1);

        // Reset held for two cycles
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        check("reset", 8'h00, 0, 3'd0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(0, vecs[i].v, vecs[i].d, vecs[i].l);
            check($sformatf("vec%0d v=%0b d=%02h l=%0b", i, vecs[i].v, vecs[i].d, vecs[i].l),
                  vecs[i].e_dout, vecs[i].e_fv, vecs[i].e_usedw, vecs[i].e_full, vecs[i].e_empty);
        end

        // Reset mid-operation overrides strobes and discards stored words
        step(0, 1, 8'hC1, 0);
        step(0, 1, 8'hC2, 0);
        check("pre_reset", 8'h20, 0, 3'd2, 0, 0);
        step(1, 1, 8'hC3, 1);
        check("mid_reset", 8'h00, 0, 3'd0, 0, 1);
        step(0, 1, 8'h3C, 0);
        step(0, 0, 8'h00, 1);
        check("after_reset_pop", 8'h3C, 1, 3'd0, 0, 1);

        // Held strobes: valid high for 6 cycles, then load high for 5 cycles
        rst_n = 1'b0; valid = 1'b1; load = 1'b0;
        for (int k = 0; k < 6; k++) begin
            din = 8'hD0 + 8'(k);
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        check("held_valid", 8'h3C, 0, 3'd4, 1, 0);
        load = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (k < 4)
                check($sformatf("held_load%0d", k), 8'hD0 + 8'(k), 1, 3'(3 - k), 0, k == 3);
            else
                check("held_load_underflow", 8'hD3, 0, 3'd0, 0, 1);
        end
        load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
